// File: rtl/sar_conv_seq.sv
// SAR conversion sequencer: drives the SAR restart phase, captures codes,
// box-car averages 2^osr_log2 of them and streams results on valid/ready.
// Ports: clk, rst_n | en, osr_log2 | sar_rst_n, sar_dq, sar_last_cycle |
//        m_data, m_valid, m_ready | overrun, timeout, err_clr | conv_busy
module sar_conv_seq #(
  parameter int N            = 12,
  parameter int OSR_MAX_LOG2 = 4,
  parameter int SAMPLE_CYC   = 2,
  parameter int TIMEOUT_CYC  = N + 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [$clog2(OSR_MAX_LOG2+1)-1:0] osr_log2,
  output logic                              sar_rst_n,
  input  logic [N-1:0]                      sar_dq,
  input  logic                              sar_last_cycle,
  output logic [N-1:0]                      m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              overrun,
  output logic                              timeout,
  input  logic                              err_clr,
  output logic                              conv_busy
);

  localparam int OW   = $clog2(OSR_MAX_LOG2 + 1);
  localparam int AW   = N + OSR_MAX_LOG2;
  localparam int SW   = OSR_MAX_LOG2 + 1;
  localparam int CMAX = (TIMEOUT_CYC > SAMPLE_CYC) ?
                        TIMEOUT_CYC : SAMPLE_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q;
  logic [SW-1:0] scnt_q;
  logic [OW-1:0] osr_q;

  logic          cap, tmo;
  logic [OW-1:0] osr_clamp, osr_use;
  logic          blk_last, new_res;
  logic [AW-1:0] sum;
  logic [N-1:0]  res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (cnt_q == CW'(SAMPLE_CYC - 1)) begin
          state_d = ST_CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CONVERT: begin
        cnt_d = cnt_q + CW'(1);
        if (sar_last_cycle) begin
          cap     = 1'b1;
          state_d = en ? ST_SAMPLE : ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          tmo     = 1'b1;
          state_d = en ? ST_SAMPLE : ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Ratio is taken live on a block's first capture, then held.
  assign osr_clamp = (osr_log2 > OW'(OSR_MAX_LOG2)) ?
                     OW'(OSR_MAX_LOG2) : osr_log2;
  assign osr_use   = (scnt_q == '0) ? osr_clamp : osr_q;
  assign blk_last  = scnt_q == ((SW'(1) << osr_use) - SW'(1));
  assign sum       = acc_q + AW'(sar_dq);
  assign res       = N'(sum >> osr_use);
  assign new_res   = cap && blk_last;
  assign conv_busy = state_q != ST_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sar_rst_n <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sar_rst_n <= state_d == ST_CONVERT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      scnt_q <= '0;
      osr_q  <= '0;
    end else if (state_q == ST_IDLE) begin
      acc_q  <= '0;
      scnt_q <= '0;
    end else if (cap) begin
      if (scnt_q == '0) osr_q <= osr_clamp;
      if (blk_last) begin
        acc_q  <= '0;
        scnt_q <= '0;
      end else begin
        acc_q  <= sum;
        scnt_q <= scnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (new_res && (!m_valid || m_ready)) begin
        m_data  <= res;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      // A fresh error event outranks a same-cycle clear.
      if (new_res && m_valid && !m_ready) overrun <= 1'b1;
      else if (err_clr)                   overrun <= 1'b0;
      if (tmo)          timeout <= 1'b1;
      else if (err_clr) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sar_conv_seq.sv
// Directed bench for sar_conv_seq with a behavioural SAR controller model.
// Checks pass-through, averaging, overrun, handshake, timeout and reset.
module tb_sar_conv_seq;

  localparam int N = 12;

  logic          tb_clk_r = 1'b0;
  logic          rst_n;
  logic          en;
  logic [2:0]    osr_log2;
  logic          sar_rst_n;
  logic [N-1:0]  sar_dq = '0;
  logic          sar_last_cycle = 1'b0;
  logic [N-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          overrun;
  logic          timeout;
  logic          err_clr;
  logic          conv_busy;

  always #5 tb_clk_r = ~tb_clk_r;

  sar_conv_seq dut (
    .clk            (tb_clk_r),
    .rst_n          (rst_n),
    .en             (en),
    .osr_log2       (osr_log2),
    .sar_rst_n      (sar_rst_n),
    .sar_dq         (sar_dq),
    .sar_last_cycle (sar_last_cycle),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .overrun        (overrun),
    .timeout        (timeout),
    .err_clr        (err_clr),
    .conv_busy      (conv_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  // SAR model: strobes N clocks after sar_rst_n rises.
  logic         model_on = 1'b0;
  logic [N-1:0] code_mem [64];
  int           strobe_cnt = 0;
  int           sar_cyc = 0;

  always @(negedge tb_clk_r) begin
    if (!sar_rst_n || !model_on) begin
      sar_cyc        = 0;
      sar_last_cycle = 1'b0;
    end else begin
      sar_cyc++;
      sar_last_cycle = (sar_cyc == N);
      if (sar_last_cycle) begin
        sar_dq = code_mem[strobe_cnt % 64];
        strobe_cnt++;
      end
    end
  end

  // Output monitor, sampled just before each rising edge.
  logic [N-1:0] rx_mem [256];
  int rx_n = 0;
  int valid_cyc = 0;
  int vrun = 0, last_vrun = 0;
  int lo_run = 0, last_lo = 0;
  int hi_run = 0, last_hi = 0;
  bit seen_hi = 1'b0;

  always @(negedge tb_clk_r) begin
    #4;
    if (m_valid && m_ready) begin
      rx_mem[rx_n % 256] = m_data;
      rx_n++;
    end
    if (m_valid) begin
      valid_cyc++;
      vrun++;
    end else if (vrun != 0) begin
      last_vrun = vrun;
      vrun = 0;
    end
    if (sar_rst_n) begin
      hi_run++;
      if (lo_run != 0 && seen_hi) last_lo = lo_run;
      lo_run  = 0;
      seen_hi = 1'b1;
    end else begin
      if (hi_run != 0) last_hi = hi_run;
      hi_run = 0;
      lo_run++;
    end
  end

  int rx_rd = 0;

  task automatic step(int n = 1);
    repeat (n) @(negedge tb_clk_r);
    #1;
  endtask

  task automatic wait_rx(string tag, logic [N-1:0] exp);
    int t = 0;
    while (rx_n <= rx_rd && t < 400) begin
      step();
      t++;
    end
    if (rx_n > rx_rd) begin
      chk_eq(tag, 32'(rx_mem[rx_rd % 256]), 32'(exp));
      rx_rd++;
    end else begin
      chk_eq({tag, "_arrived"}, 32'(rx_n - rx_rd), 32'd1);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (conv_busy && t < 100) begin
      step();
      t++;
    end
  endtask

  task automatic wait_strobes(int target);
    int t = 0;
    while (strobe_cnt < target && t < 500) begin
      step();
      t++;
    end
  endtask

  task automatic load_codes(int base, int n, logic [N-1:0] v);
    for (int i = 0; i < n; i++) code_mem[(base + i) % 64] = v;
  endtask

  initial begin
    int base;
    int vbase;
    int t;
    rst_n    = 1'b0;
    en       = 1'b0;
    osr_log2 = 3'd0;
    m_ready  = 1'b0;
    err_clr  = 1'b0;
    for (int i = 0; i < 64; i++) code_mem[i] = '0;
    step(3);
    chk_eq("rst_sar_rst_n", 32'(sar_rst_n), 32'd0);
    chk_eq("rst_m_valid", 32'(m_valid), 32'd0);
    chk_eq("rst_m_data", 32'(m_data), 32'd0);
    chk_eq("rst_overrun", 32'(overrun), 32'd0);
    chk_eq("rst_timeout", 32'(timeout), 32'd0);
    chk_eq("rst_conv_busy", 32'(conv_busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Pass-through
    load_codes(strobe_cnt, 8, 12'hA5C);
    model_on = 1'b1;
    m_ready  = 1'b1;
    en       = 1'b1;
    wait_rx("pt0", 12'hA5C);
    wait_rx("pt1", 12'hA5C);
    en = 1'b0;
    wait_idle();
    step(3);
    chk_eq("pt_sample_len", 32'(last_lo), 32'd2);
    chk_eq("pt_valid_len", 32'(last_vrun), 32'd1);
    rx_rd = rx_n;

    // Averaging by 4
    base = strobe_cnt;
    load_codes(base, 8, 12'd0);
    code_mem[(base + 0) % 64] = 12'd100;
    code_mem[(base + 1) % 64] = 12'd101;
    code_mem[(base + 2) % 64] = 12'd102;
    code_mem[(base + 3) % 64] = 12'd104;
    osr_log2 = 3'd2;
    en = 1'b1;
    wait_strobes(base + 3);
    step(4);
    chk_eq("avg_early_rx", 32'(rx_n - rx_rd), 32'd0);
    chk_eq("avg_early_valid", 32'(m_valid), 32'd0);
    wait_rx("avg", 12'd101);
    en = 1'b0;
    wait_idle();
    rx_rd = rx_n;

    // Clamped ratio: 5 acts as 4, i.e. 16 captures
    base = strobe_cnt;
    load_codes(base, 40, 12'd0);
    code_mem[base % 64] = 12'h100;
    osr_log2 = 3'd5;
    en = 1'b1;
    wait_rx("osr_clamp", 12'h010);
    en = 1'b0;
    wait_idle();
    rx_rd = rx_n;

    // Overrun
    base = strobe_cnt;
    load_codes(base, 8, 12'h000);
    code_mem[(base + 0) % 64] = 12'h111;
    code_mem[(base + 1) % 64] = 12'h222;
    code_mem[(base + 2) % 64] = 12'h333;
    osr_log2 = 3'd0;
    m_ready  = 1'b0;
    en       = 1'b1;
    wait_strobes(base + 2);
    step(2);
    chk_eq("ovr_data_kept", 32'(m_data), 32'h111);
    chk_eq("ovr_valid", 32'(m_valid), 32'd1);
    chk_eq("ovr_flag", 32'(overrun), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk_eq("ovr_clear", 32'(overrun), 32'd0);

    // Ready rises on the edge the next result lands; en drops too
    t = 0;
    while (!sar_last_cycle && t < 40) begin
      step();
      t++;
    end
    m_ready = 1'b1;
    en      = 1'b0;
    step();
    chk_eq("sim_data", 32'(m_data), 32'h333);
    chk_eq("sim_valid", 32'(m_valid), 32'd1);
    chk_eq("sim_overrun", 32'(overrun), 32'd0);
    chk_eq("endrop_busy", 32'(conv_busy), 32'd0);
    chk_eq("endrop_sar_rst", 32'(sar_rst_n), 32'd0);
    wait_rx("sim_old", 12'h111);
    wait_rx("sim_new", 12'h333);
    wait_idle();
    rx_rd = rx_n;

    // Timeout
    vbase    = valid_cyc;
    model_on = 1'b0;
    en       = 1'b1;
    t = 0;
    while (!timeout && t < 60) begin
      step();
      t++;
    end
    step();
    chk_eq("tmo_flag", 32'(timeout), 32'd1);
    chk_eq("tmo_conv_len", 32'(last_hi), 32'd16);
    chk_eq("tmo_resample", 32'(conv_busy && !sar_rst_n), 32'd1);
    chk_eq("tmo_no_valid", 32'(valid_cyc - vbase), 32'd0);
    en = 1'b0;
    wait_idle();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk_eq("tmo_clear", 32'(timeout), 32'd0);

    // Asynchronous reset mid-block
    model_on = 1'b1;
    base = strobe_cnt;
    load_codes(base, 8, 12'd200);
    osr_log2 = 3'd2;
    m_ready  = 1'b0;
    en       = 1'b1;
    wait_strobes(base + 2);
    step();
    rst_n = 1'b0;
    #1;
    chk_eq("arst_m_data", 32'(m_data), 32'd0);
    chk_eq("arst_m_valid", 32'(m_valid), 32'd0);
    chk_eq("arst_sar_rst_n", 32'(sar_rst_n), 32'd0);
    chk_eq("arst_busy", 32'(conv_busy), 32'd0);
    step(2);
    base = strobe_cnt;
    load_codes(base, 8, 12'd0);
    code_mem[(base + 0) % 64] = 12'd40;
    code_mem[(base + 1) % 64] = 12'd40;
    code_mem[(base + 2) % 64] = 12'd40;
    code_mem[(base + 3) % 64] = 12'd48;
    m_ready = 1'b1;
    rx_rd   = rx_n;
    rst_n   = 1'b1;
    wait_rx("post_rst_avg", 12'd42);
    en = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sar_conv_seq.md
Name: sar_conv_seq

Overview:
- Sequencer and result post-processor sitting directly downstream of the synchronous SAR controller.
- Generates the SAR controller's conversion-restart (sample) phase, captures the final code on the controller's last-cycle strobe, and box-car averages 2^osr_log2 codes.
- Presents each averaged word on a valid/ready stream toward the digital backend, with timeout and overrun error reporting.

Parameters:
- N, 12, SAR code width.
- OSR_MAX_LOG2, 4, maximum log2 oversampling ratio; the accumulator is N+OSR_MAX_LOG2 bits.
- SAMPLE_CYC, 2, clocks the SAR controller is held in reset (sampling phase) before each conversion; must be ≥1.
- TIMEOUT_CYC, N+4, max clocks in CONVERT without sar_last_cycle before abort.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; level sensitive.
- osr_log2  in  $clog2(OSR_MAX_LOG2+1)  averaging ratio log2; values above OSR_MAX_LOG2 are clamped.
- sar_rst_n  out  1  registered active-low reset to the SAR controller.
- sar_dq  in  N  SAR controller code.
- sar_last_cycle  in  1  SAR controller final-bit strobe; sar_dq is valid while it is high.
- m_data  out  N  averaged result.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer ready.
- overrun  out  1  sticky: a result was dropped.
- timeout  out  1  sticky: a conversion aborted.
- err_clr  in  1  synchronous clear of overrun and timeout.
- conv_busy  out  1  high in SAMPLE or CONVERT.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream) sets:
  - state IDLE, sar_rst_n=0, m_valid=0, m_data=0, overrun=0, timeout=0, conv_busy=0.
  - accumulator=0, sample count=0, phase/timeout counter=0.
- FSM states: IDLE, SAMPLE, CONVERT.
- IDLE:
  - sar_rst_n=0; accumulator and count are cleared.
  - en=1 moves to SAMPLE on the next clock.
- SAMPLE:
  - sar_rst_n=0 for exactly SAMPLE_CYC clocks, then CONVERT.
- CONVERT:
  - sar_rst_n=1; the timeout counter increments each clock.
  - On a clock edge with sar_last_cycle=1: capture sar_dq into the accumulator, then go to SAMPLE if en=1, else IDLE. sar_rst_n is low in the clock following capture.
  - If the counter reaches TIMEOUT_CYC with no strobe: set timeout, discard nothing already accumulated, and go to SAMPLE (or IDLE if en=0). There is no capture for that slot.
  - sar_last_cycle outside CONVERT is ignored.
- Block length and latching:
  - The effective osr_log2 is latched when the sample count is 0 (first capture of a block); mid-block changes take effect on the next block.
  - Block length is 2^osr_log2 captures; osr_log2=0 gives pass-through.
- Result formation:
  - On the final capture of a block: result = (acc + sar_dq) >> osr_log2, truncated to N bits (no rounding).
  - Accumulator and count then clear in the same clock.
  - The result is offered to the output register on that edge.
- Output handshake:
  - Transfer occurs on a clock with m_valid && m_ready.
  - m_data is stable while m_valid=1 && m_ready=0.
  - New result with m_valid=0 → load; m_valid=1 next clock.
  - New result with m_valid=1 and m_ready=1 on the same clock → old word transfers, new word loads, m_valid stays 1, no overrun.
  - New result with m_valid=1 and m_ready=0 → new result dropped, old word kept, overrun=1.
- Error flags:
  - err_clr=1 clears overrun and timeout.
  - If err_clr coincides with a new error event, the event wins (flag = 1).
- en deasserted mid-SAMPLE or mid-CONVERT: the current conversion completes (capture or timeout), then IDLE. The partial block is discarded on entering IDLE; m_valid and its pending word are unaffected.
- conv_busy = (state != IDLE).

Test Plan:
- Pass-through:
  - Stimulus: osr_log2=0, SAMPLE_CYC=2, en=1; SAR model returns 0xA5C with last_cycle N clocks after sar_rst_n rises; m_ready=1.
  - Required: m_data=0xA5C, m_valid for 1 clock; sar_rst_n low exactly 2 clocks between conversions.
- Averaging:
  - Stimulus: osr_log2=2, codes 100,101,102,104.
  - Required: one output = 101 (407>>2); no output after the first three captures.
- Overrun:
  - Stimulus: osr_log2=0, m_ready=0 across two results (0x111, then 0x222).
  - Required: m_data remains 0x111, overrun=1.
  - Stimulus: assert err_clr.
  - Required: overrun=0.
- Simultaneous handshake:
  - Stimulus: m_ready rises on the same edge the next result (0x333) lands.
  - Required: 0x111 transfers, m_data=0x333, m_valid stays 1, overrun=0.
- Timeout:
  - Stimulus: SAR model never asserts last_cycle.
  - Required: after TIMEOUT_CYC=16 clocks in CONVERT, timeout=1, FSM re-enters SAMPLE, no m_valid.
- Mid-operation events:
  - en dropped during CONVERT → capture completes, FSM goes IDLE, sar_rst_n=0.
  - rst_n asserted mid-block → all outputs at reset values immediately (asynchronous).
  - After rst_n release, next block starts with accumulator 0.
